// File: rtl/decode_fwd_unit_pkg.sv
// Shared types and constants for the 16-bit MIPS decode/issue stage:
// opcodes, ALU and mux-select encodings, and the issue history entry.
package mips16_pkg;

    localparam int IW  = 32;
    localparam int DW  = 16;
    localparam int RAW = 5;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_AND  = 6'd3;
    localparam logic [5:0] OP_OR   = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_ANDI = 6'd9;
    localparam logic [5:0] OP_LW   = 6'd12;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4
    } alu_op_t;

    typedef enum logic [1:0] {
        SEL_RF = 2'b00,
        SEL_EX = 2'b01,
        SEL_DM = 2'b10,
        SEL_WB = 2'b11
    } mux_sel_t;

    typedef struct packed {
        logic           valid;
        logic [RAW-1:0] rw;
        logic           wr_en;
        logic           is_load;
    } hist_entry_t;

    typedef struct packed {
        logic    use_a;
        logic    use_b;
        logic    writes;
        logic    is_load;
        logic    imm_sel;
        alu_op_t alu_op;
    } dec_t;

    // Unknown opcodes fall through to the NOP decode: no reads, no write.
    function automatic dec_t decode_op(input logic [5:0] op);
        dec_t d;
        d = '{use_a: 1'b0, use_b: 1'b0, writes: 1'b0, is_load: 1'b0,
              imm_sel: 1'b0, alu_op: ALU_NOP};
        case (op)
            OP_ADD:  d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALU_ADD};
            OP_SUB:  d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALU_SUB};
            OP_AND:  d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALU_AND};
            OP_OR:   d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALU_OR};
            OP_ADDI: d = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ALU_ADD};
            OP_ANDI: d = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ALU_AND};
            OP_LW:   d = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, ALU_ADD};
            default: d = d;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_fwd_unit_if.sv
// Fetch-side instruction handshake plus the issue bundle toward register_bank/EX.
// valid/ready: instr transfers on a cycle where instr_valid && instr_ready; instr_ready does not depend on anything but instr_valid, instr and history.
interface decode_fwd_unit_if;
    import mips16_pkg::*;

    logic [IW-1:0]  instr;
    logic           instr_valid;
    logic           instr_ready;
    logic [RAW-1:0] RA;
    logic [RAW-1:0] RB;
    logic [DW-1:0]  imm;
    logic           imm_sel;
    logic [1:0]     mux_sel_A;
    logic [1:0]     mux_sel_B;
    logic [3:0]     alu_op;
    logic [RAW-1:0] rw_out;
    logic           wr_en_out;
    logic           is_load_out;
    logic           issue_valid;

    modport master (
        output instr, instr_valid,
        input  instr_ready, RA, RB, imm, imm_sel, mux_sel_A, mux_sel_B,
               alu_op, rw_out, wr_en_out, is_load_out, issue_valid
    );

    modport slave (
        input  instr, instr_valid,
        output instr_ready, RA, RB, imm, imm_sel, mux_sel_A, mux_sel_B,
               alu_op, rw_out, wr_en_out, is_load_out, issue_valid
    );

endinterface

// File: rtl/decode_fwd_unit_fwd_select.sv
// Forwarding comparator for one source operand against the three-deep issue
// history; youngest matching producer wins.
module decode_fwd_unit_fwd_select
    import mips16_pkg::*;
(
    input  logic [RAW-1:0] src,
    input  logic           used,
    input  hist_entry_t    h1,
    input  hist_entry_t    h2,
    input  hist_entry_t    h3,
    output logic [1:0]     sel,
    output logic           load_hit
);

    logic hit1, hit2, hit3;

    // r0 is never a producer, even if a stale entry claimed it.
    assign hit1 = used && (src != '0) && h1.valid && h1.wr_en && (h1.rw == src);
    assign hit2 = used && (src != '0) && h2.valid && h2.wr_en && (h2.rw == src);
    assign hit3 = used && (src != '0) && h3.valid && h3.wr_en && (h3.rw == src);

    always_comb begin
        sel = SEL_RF;
        if (hit1)      sel = SEL_EX;
        else if (hit2) sel = SEL_DM;
        else if (hit3) sel = SEL_WB;
    end

    assign load_hit = hit1 && h1.is_load;

endmodule

// File: rtl/decode_fwd_unit.sv
// Decode/issue stage: registers operand addresses and forwarding selects for
// register_bank and inserts a single bubble on load-use hazards.
module decode_fwd_unit
    import mips16_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    decode_fwd_unit_if.slave     bus
);

    logic [5:0]     op;
    logic [RAW-1:0] f_rw, f_ra, f_rb;
    logic [DW-1:0]  f_imm;
    dec_t           dec;
    logic           wr_en;
    logic [1:0]     sel_a, sel_b;
    logic           load_hit_a, load_hit_b;
    logic           stall, issue;
    hist_entry_t    h1, h2, h3;

    assign op    = bus.instr[31:26];
    assign f_rw  = bus.instr[25:21];
    assign f_ra  = bus.instr[20:16];
    assign f_rb  = bus.instr[15:11];
    assign f_imm = bus.instr[15:0];
    assign dec   = decode_op(op);
    assign wr_en = dec.writes && (f_rw != '0);

    decode_fwd_unit_fwd_select u_sel_a (
        .src      (f_ra),
        .used     (dec.use_a),
        .h1       (h1),
        .h2       (h2),
        .h3       (h3),
        .sel      (sel_a),
        .load_hit (load_hit_a)
    );

    decode_fwd_unit_fwd_select u_sel_b (
        .src      (f_rb),
        .used     (dec.use_b),
        .h1       (h1),
        .h2       (h2),
        .h3       (h3),
        .sel      (sel_b),
        .load_hit (load_hit_b)
    );

    // A load result is only available from DM, so a consumer right behind it waits one cycle.
    assign stall           = bus.instr_valid && (load_hit_a || load_hit_b);
    assign issue           = bus.instr_valid && !stall;
    assign bus.instr_ready = !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.RA          <= '0;
            bus.RB          <= '0;
            bus.imm         <= '0;
            bus.imm_sel     <= 1'b0;
            bus.mux_sel_A   <= SEL_RF;
            bus.mux_sel_B   <= SEL_RF;
            bus.alu_op      <= ALU_NOP;
            bus.rw_out      <= '0;
            bus.wr_en_out   <= 1'b0;
            bus.is_load_out <= 1'b0;
            bus.issue_valid <= 1'b0;
            h1              <= '0;
            h2              <= '0;
            h3              <= '0;
        end else begin
            h3 <= h2;
            h2 <= h1;
            if (issue) begin
                bus.RA          <= f_ra;
                bus.RB          <= f_rb;
                bus.imm         <= f_imm;
                bus.imm_sel     <= dec.imm_sel;
                bus.mux_sel_A   <= sel_a;
                bus.mux_sel_B   <= sel_b;
                bus.alu_op      <= dec.alu_op;
                bus.rw_out      <= f_rw;
                bus.wr_en_out   <= wr_en;
                bus.is_load_out <= dec.is_load;
                bus.issue_valid <= 1'b1;
                h1              <= '{valid: 1'b1, rw: f_rw, wr_en: wr_en, is_load: dec.is_load};
            end else begin
                bus.RA          <= '0;
                bus.RB          <= '0;
                bus.imm         <= '0;
                bus.imm_sel     <= 1'b0;
                bus.mux_sel_A   <= SEL_RF;
                bus.mux_sel_B   <= SEL_RF;
                bus.alu_op      <= ALU_NOP;
                bus.rw_out      <= '0;
                bus.wr_en_out   <= 1'b0;
                bus.is_load_out <= 1'b0;
                bus.issue_valid <= 1'b0;
                h1              <= '0;
            end
        end
    end

endmodule

// File: tb/tb_decode_fwd_unit.sv
// Directed bench for decode_fwd_unit: forwarding priority, load-use bubble,
// r0 suppression and asynchronous reset.
module tb_decode_fwd_unit;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    decode_fwd_unit_if bus ();

    decode_fwd_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input logic [5:0] op, input logic [4:0] rw,
                                           input logic [4:0] ra, input logic [4:0] rb);
        return {op, rw, ra, rb, 11'b0};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rw,
                                           input logic [4:0] ra, input logic [15:0] imm);
        return {op, rw, ra, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an instruction (or idle) and advance to just after the next edge.
    task automatic step(input logic valid, input logic [31:0] iw);
        bus.instr_valid = valid;
        bus.instr       = iw;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ra"},    32'(bus.RA), 32'h0);
        chk({tag, "_rb"},    32'(bus.RB), 32'h0);
        chk({tag, "_imm"},   32'(bus.imm), 32'h0);
        chk({tag, "_misc"},  {21'b0, bus.imm_sel, bus.mux_sel_A, bus.mux_sel_B,
                              bus.alu_op, bus.wr_en_out, bus.is_load_out}, 32'h0);
        chk({tag, "_rw"},    32'(bus.rw_out), 32'h0);
        chk({tag, "_valid"}, 32'(bus.issue_valid), 32'h0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        rst_n           = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset_ready", 32'(bus.instr_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(1);
        chk("idle_valid", 32'(bus.issue_valid), 32'h0);
        chk("idle_ready", 32'(bus.instr_ready), 32'h1);

        // ADD r1,r2,r3 ; ADD r4,r1,r1
        step(1'b1, r_type(6'd1, 5'd1, 5'd2, 5'd3));
        chk("add1_valid", 32'(bus.issue_valid), 32'h1);
        chk("add1_ra",    32'(bus.RA), 32'd2);
        chk("add1_rb",    32'(bus.RB), 32'd3);
        chk("add1_sel",   {28'b0, bus.mux_sel_A, bus.mux_sel_B}, 32'h0);
        chk("add1_alu",   32'(bus.alu_op), 32'd1);
        chk("add1_rw",    32'(bus.rw_out), 32'd1);
        chk("add1_wr",    32'(bus.wr_en_out), 32'h1);
        chk("add1_isel",  32'(bus.imm_sel), 32'h0);
        step(1'b1, r_type(6'd1, 5'd4, 5'd1, 5'd1));
        chk("fwd_ex_a", 32'(bus.mux_sel_A), 32'h1);
        chk("fwd_ex_b", 32'(bus.mux_sel_B), 32'h1);
        chk("fwd_ex_rw", 32'(bus.rw_out), 32'd4);
        idle(1);
        chk("bubble_valid", 32'(bus.issue_valid), 32'h0);
        idle(2);

        // ADD r1 ; NOP ; NOP ; ADDI r5,r1,#7
        step(1'b1, r_type(6'd1, 5'd1, 5'd2, 5'd3));
        step(1'b1, 32'h0);
        chk("nop_valid", 32'(bus.issue_valid), 32'h1);
        chk("nop_wr",    32'(bus.wr_en_out), 32'h0);
        chk("nop_alu",   32'(bus.alu_op), 32'h0);
        step(1'b1, 32'h0);
        step(1'b1, i_type(6'd8, 5'd5, 5'd1, 16'h0007));
        chk("addi_sel_a", 32'(bus.mux_sel_A), 32'h3);
        chk("addi_sel_b", 32'(bus.mux_sel_B), 32'h0);
        chk("addi_isel",  32'(bus.imm_sel), 32'h1);
        chk("addi_imm",   32'(bus.imm), 32'h0007);
        chk("addi_alu",   32'(bus.alu_op), 32'd1);
        idle(3);

        // LW r2,4(r1) ; ADD r6,r2,r3 -> one bubble
        step(1'b1, i_type(6'd12, 5'd2, 5'd1, 16'h0004));
        chk("lw_load", 32'(bus.is_load_out), 32'h1);
        chk("lw_wr",   32'(bus.wr_en_out), 32'h1);
        chk("lw_ra",   32'(bus.RA), 32'd1);
        bus.instr_valid = 1'b1;
        bus.instr       = r_type(6'd1, 5'd6, 5'd2, 5'd3);
        #1;
        chk("lu_ready_low", 32'(bus.instr_ready), 32'h0);
        step(1'b1, r_type(6'd1, 5'd6, 5'd2, 5'd3));
        chk("lu_bubble_valid", 32'(bus.issue_valid), 32'h0);
        chk("lu_bubble_wr",    32'(bus.wr_en_out), 32'h0);
        chk("lu_bubble_sel",   {28'b0, bus.mux_sel_A, bus.mux_sel_B}, 32'h0);
        chk("lu_ready_high", 32'(bus.instr_ready), 32'h1);
        step(1'b1, r_type(6'd1, 5'd6, 5'd2, 5'd3));
        chk("lu_issue_valid", 32'(bus.issue_valid), 32'h1);
        chk("lu_sel_a",       32'(bus.mux_sel_A), 32'h2);
        chk("lu_sel_b",       32'(bus.mux_sel_B), 32'h0);
        chk("lu_rw",          32'(bus.rw_out), 32'd6);
        idle(3);

        // ADD r0,r1,r1 ; ADD r7,r0,r0
        step(1'b1, r_type(6'd1, 5'd0, 5'd1, 5'd1));
        chk("r0_wr", 32'(bus.wr_en_out), 32'h0);
        chk("r0_valid", 32'(bus.issue_valid), 32'h1);
        step(1'b1, r_type(6'd1, 5'd7, 5'd0, 5'd0));
        chk("r0_src_sel", {28'b0, bus.mux_sel_A, bus.mux_sel_B}, 32'h0);
        idle(3);

        // ADD r1 ; ADD r1 ; ADD r8,r1,r2 -> youngest wins
        step(1'b1, r_type(6'd1, 5'd1, 5'd2, 5'd3));
        step(1'b1, r_type(6'd1, 5'd1, 5'd4, 5'd5));
        step(1'b1, r_type(6'd1, 5'd8, 5'd1, 5'd2));
        chk("young_sel_a", 32'(bus.mux_sel_A), 32'h1);
        chk("young_sel_b", 32'(bus.mux_sel_B), 32'h0);
        idle(3);

        // Mid-stream asynchronous reset clears outputs and history
        step(1'b1, r_type(6'd1, 5'd1, 5'd2, 5'd3));
        chk("pre_rst_valid", 32'(bus.issue_valid), 32'h1);
        bus.instr = r_type(6'd1, 5'd9, 5'd1, 5'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, r_type(6'd1, 5'd9, 5'd1, 5'd1));
        chk("post_rst_valid", 32'(bus.issue_valid), 32'h1);
        chk("post_rst_sel", {28'b0, bus.mux_sel_A, bus.mux_sel_B}, 32'h0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
